// File: rtl/sc_pkg.sv
// Shared types and sizing helpers for the stochastic stream decoder.
// Holds the decoder FSM encoding and the length-width arithmetic.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } sc_state_e;

  function automatic int sc_cnt_w(input int width, input int num);
    return width * num;
  endfunction

  function automatic int sc_len_w(input int cnt_w);
    return $clog2(cnt_w + 1);
  endfunction

endpackage

// File: rtl/sc_ones_ctr.sv
// Saturating ones counter for one stochastic channel.
// Clear has priority over enable; the count sticks at all-ones.
module sc_ones_ctr #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Decodes parallel stochastic bitstreams into binary values by
// counting ones over a 2^len_log2 beat frame and rescaling.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int NUM_INPUTS = 8,
  localparam int CNT_W      = sc_cnt_w(WIDTH, NUM_INPUTS),
  localparam int LW         = sc_len_w(CNT_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LW-1:0]         len_log2,
  input  logic                  bit_valid,
  input  logic [NUM_INPUTS-1:0] bits,
  input  logic                  last,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      Bx_est [NUM_INPUTS-1:0],
  output logic                  err_len
);

  localparam int XW = CNT_W + 1 + WIDTH;
  localparam logic [LW-1:0] CNT_L = LW'(CNT_W);
  localparam logic [LW-1:0] WID_L = LW'(WIDTH);

  sc_state_e      state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [CNT_W:0] beat_q, beat_d;
  logic           err_q, err_d;

  logic           clr;
  logic           en;
  logic           restart;
  logic [LW-1:0]  len_clamp;
  logic [CNT_W:0] len_cnt;
  logic [CNT_W:0] beat_nxt;
  logic [CNT_W:0] ones [NUM_INPUTS-1:0];

  assign len_clamp = (len_log2 > CNT_L) ? CNT_L : len_log2;
  assign len_cnt   = {{CNT_W{1'b0}}, 1'b1} << len_q;
  assign beat_nxt  = (beat_q == '1) ? beat_q : beat_q + (CNT_W+1)'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    clr     = 1'b0;
    en      = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        restart = start;
      end
      ST_ACCUM: begin
        if (start) begin
          restart = 1'b1;
        end else if (bit_valid) begin
          en     = 1'b1;
          beat_d = beat_nxt;
          // Overrun flags as soon as it happens; short frames at last.
          err_d  = err_q | (beat_nxt > len_cnt)
                 | (last && (beat_nxt != len_cnt));
          if (last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          restart = start;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (restart) begin
      state_d = ST_ACCUM;
      clr     = 1'b1;
      len_d   = len_clamp;
      beat_d  = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ctr
    sc_ones_ctr #(
      .W (CNT_W + 1)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (en),
      .inc   (bits[i]),
      .cnt   (ones[i])
    );
  end

  // Counters are frozen outside ACCUM, so the result holds in DONE.
  always_comb begin
    logic [XW-1:0] wide;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      wide = XW'(ones[i]);
      if (len_q >= WID_L) begin
        wide = wide >> (len_q - WID_L);
      end else begin
        wide = wide << (WID_L - len_q);
      end
      Bx_est[i] = (|wide[XW-1:WIDTH]) ? '1 : wide[WIDTH-1:0];
    end
  end

  assign busy      = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign err_len   = err_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder at WIDTH=4, NUM_INPUTS=2.
// Uses directed frame vectors, corner sequences and random frames.
module tb_sc_stream_decoder;

  localparam int WIDTH = 4;
  localparam int NIN   = 2;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [3:0]     len_log2;
  logic           bit_valid;
  logic [NIN-1:0] bits;
  logic           last;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [WIDTH-1:0] bx [NIN-1:0];
  logic           err_len;

  int checks;
  int errors;

  sc_stream_decoder #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len_log2  (len_log2),
    .bit_valid (bit_valid),
    .bits      (bits),
    .last      (last),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Bx_est    (bx),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int n;
    int o0;
    int o1;
    int e0;
    int e1;
    int eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start    = 1'b1;
    len_log2 = 4'(len);
    tick();
    start    = 1'b0;
  endtask

  // Beats where channel c is 1 for the first oc beats.
  task automatic send_beats(input int n, input int o0, input int o1,
                            input bit with_last);
    for (int b = 0; b < n; b++) begin
      bit_valid = 1'b1;
      bits[0]   = (b < o0);
      bits[1]   = (b < o1);
      last      = with_last && (b == n - 1);
      tick();
    end
    bit_valid = 1'b0;
    last      = 1'b0;
    bits      = '0;
  endtask

  task automatic check_result(input string nm, input int e0,
                              input int e1, input int eerr);
    chk({nm, ".out_valid"}, 32'(out_valid), 1);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".bx0"}, 32'(bx[0]), 32'(e0));
    chk({nm, ".bx1"}, 32'(bx[1]), 32'(e1));
    chk({nm, ".err"}, 32'(err_len), 32'(eerr));
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept.out_valid", 32'(out_valid), 0);
  endtask

  function automatic int ref_val(input int ones, input int lc);
    int v;
    v = (ones * (1 << WIDTH)) / (1 << lc);
    return (v > (1 << WIDTH) - 1) ? (1 << WIDTH) - 1 : v;
  endfunction

  vec_t tbl [7];

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len_log2  = '0;
    bit_valid = 1'b0;
    bits      = '0;
    last      = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{len: 8, n: 256, o0: 96,  o1: 200, e0: 6,  e1: 12, eerr: 0};
    tbl[1] = '{len: 4, n: 16,  o0: 16,  o1: 5,   e0: 15, e1: 5,  eerr: 0};
    tbl[2] = '{len: 8, n: 200, o0: 100, o1: 50,  e0: 6,  e1: 3,  eerr: 1};
    tbl[3] = '{len: 0, n: 1,   o0: 1,   o1: 0,   e0: 15, e1: 0,  eerr: 0};
    tbl[4] = '{len: 2, n: 4,   o0: 3,   o1: 1,   e0: 12, e1: 4,  eerr: 0};
    tbl[5] = '{len: 3, n: 10,  o0: 5,   o1: 10,  e0: 10, e1: 15, eerr: 1};
    tbl[6] = '{len: 12, n: 256, o0: 128, o1: 255, e0: 8, e1: 15, eerr: 0};

    #12;
    chk("reset.busy", 32'(busy), 0);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.err", 32'(err_len), 0);
    chk("reset.bx0", 32'(bx[0]), 0);
    chk("reset.bx1", 32'(bx[1]), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Beats while idle must not start anything.
    send_beats(5, 5, 5, 1'b1);
    chk("idle.out_valid", 32'(out_valid), 0);
    chk("idle.busy", 32'(busy), 0);

    for (int t = 0; t < 7; t++) begin
      do_start(tbl[t].len);
      chk($sformatf("vec%0d.busy", t), 32'(busy), 1);
      send_beats(tbl[t].n, tbl[t].o0, tbl[t].o1, 1'b1);
      check_result($sformatf("vec%0d", t), tbl[t].e0, tbl[t].e1,
                   tbl[t].eerr);
      accept();
    end

    // Stall in DONE, with ignored beats, then accept+start together.
    do_start(2);
    send_beats(4, 2, 4, 1'b1);
    for (int c = 0; c < 10; c++) begin
      bit_valid = 1'b1;
      bits      = 2'b11;
      last      = 1'b1;
      tick();
      check_result($sformatf("stall%0d", c), 8, 15, 0);
    end
    bit_valid = 1'b0;
    last      = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    len_log2  = 4'd2;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("b2b.busy", 32'(busy), 1);
    chk("b2b.out_valid", 32'(out_valid), 0);
    send_beats(4, 1, 0, 1'b1);
    check_result("b2b", 4, 0, 0);
    accept();

    // Abort mid-frame by restarting with a different length.
    do_start(4);
    send_beats(7, 7, 7, 1'b0);
    do_start(2);
    send_beats(4, 1, 2, 1'b1);
    check_result("abort", 4, 8, 0);
    accept();

    // Reset in the middle of a frame.
    do_start(8);
    send_beats(100, 50, 50, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.err", 32'(err_len), 0);
    chk("midrst.bx0", 32'(bx[0]), 0);
    chk("midrst.bx1", 32'(bx[1]), 0);
    tick();
    rst_n = 1'b1;
    send_beats(156, 100, 100, 1'b1);
    tick();
    chk("postrst.out_valid", 32'(out_valid), 0);
    chk("postrst.bx0", 32'(bx[0]), 0);

    // Random frames against the arithmetic model.
    for (int f = 0; f < 16; f++) begin
      int len;
      int lc;
      int n;
      int o0;
      int o1;
      int sent;
      len  = int'($urandom_range(0, 10));
      lc   = (len > 8) ? 8 : len;
      n    = ($urandom_range(0, 1) == 1) ? (1 << lc)
                                         : int'($urandom_range(1, 300));
      o0   = 0;
      o1   = 0;
      sent = 0;
      do_start(len);
      while (sent < n) begin
        if ($urandom_range(0, 3) == 0) begin
          bit_valid = 1'b0;
          last      = 1'($urandom_range(0, 1));
          bits      = 2'($urandom);
        end else begin
          bit_valid = 1'b1;
          bits      = 2'($urandom);
          last      = (sent == n - 1);
          o0        = o0 + int'(bits[0]);
          o1        = o1 + int'(bits[1]);
          sent++;
        end
        tick();
      end
      bit_valid = 1'b0;
      last      = 1'b0;
      check_result($sformatf("rnd%0d", f), ref_val(o0, lc),
                   ref_val(o1, lc), (n != (1 << lc)) ? 1 : 0);
      accept();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each decoded binary value.
REQ-002 SHALL have parameter NUM_INPUTS, default 8: number of parallel stochastic bitstream channels.
REQ-003 SHALL have localparam CNT_W = WIDTH*NUM_INPUTS: maximum log2 stream length.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-005 Port clk: input, 1 bit, sole clock, rising edge.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port start: input, 1 bit, begins a decode frame and samples len_log2.
REQ-008 Port len_log2: input, $clog2(CNT_W+1) bits, log2 of the expected stream length L.
REQ-009 Port bit_valid: input, 1 bit, qualifies bits as one stream beat.
REQ-010 Port bits: input, NUM_INPUTS bits, one stochastic bit per channel.
REQ-011 Port last: input, 1 bit, marks the final beat; qualified by bit_valid; driven from the generator's done.
REQ-012 Port busy: output, 1 bit, high while in ACCUM.
REQ-013 Port out_valid: output, 1 bit, Bx_est holds a completed result.
REQ-014 Port out_ready: input, 1 bit, consumer accepts the result.
REQ-015 Port Bx_est: output, unpacked array [NUM_INPUTS-1:0] of WIDTH bits, decoded binary values.
REQ-016 Port err_len: output, 1 bit, sticky length-mismatch flag for the last frame.

Function
REQ-017 FSM SHALL have states IDLE, ACCUM and DONE.
REQ-018 IDLE->ACCUM on start: clear all ones counters and the beat counter, latch len_log2 clamped to [0, CNT_W], clear err_len.
REQ-019 In ACCUM, each bit_valid beat SHALL increment beat counter by 1 and ones counter i by bits[i]; counters are CNT_W+1 bits wide.
REQ-020 ACCUM->DONE on bit_valid & last; that beat is counted; on the next cycle out_valid=1 and Bx_est holds the result (1-cycle latency).
REQ-021 Result per channel: if latched len_log2 >= WIDTH, ones >> (len_log2-WIDTH); else ones << (WIDTH-len_log2); saturate to 2^WIDTH-1.
REQ-022 err_len SHALL be set if the final beat count != 2^len_log2; beats beyond 2^len_log2 before last SHALL also set it, and counters SHALL saturate rather than wrap.
REQ-023 DONE: out_valid and Bx_est SHALL stay stable until out_valid & out_ready; then go to IDLE, or directly to ACCUM if start is high in the same cycle.
REQ-024 bit_valid beats in IDLE or DONE SHALL be ignored with no state change.
REQ-025 start while in ACCUM SHALL abort the frame and restart accumulation with the new len_log2; no result is emitted.
REQ-026 last without bit_valid SHALL be ignored.

Reset
REQ-027 On rst_n low: state IDLE, all counters 0, busy=0, out_valid=0, err_len=0, Bx_est all 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; no out_valid after release until a new start/last sequence completes.

Structure
REQ-029 Shared package sc_pkg SHALL hold the FSM state enum and the CNT_W length-width helper.
REQ-030 Sub-module sc_ones_ctr SHALL implement one saturating (CNT_W+1)-bit ones counter with clear and enable, instantiated NUM_INPUTS times.

Verification (WIDTH=4, NUM_INPUTS=2, CNT_W=8)
REQ-031 start, len_log2=8, 256 beats with ch0 ones=96 and ch1 ones=200, last on beat 256 -> out_valid next cycle, Bx_est={12,6}, err_len=0.
REQ-032 len_log2=4 (early-terminated stream), 16 beats with ch0 ones=16 and ch1 ones=5 -> Bx_est[0]=15 (saturated), Bx_est[1]=5.
REQ-033 len_log2=8, last on beat 200 -> out_valid=1, err_len=1; Bx_est computed from the 200 counted beats.
REQ-034 out_ready held low for 10 cycles in DONE -> Bx_est and out_valid stable throughout; out_ready and start together -> next cycle busy=1, out_valid=0.
REQ-035 rst_n pulsed low at beat 100 of 256 -> all outputs 0; subsequent beats with no start produce no out_valid.
